// File: rtl/hdmi_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_frame_monitor
// Description : Frame checker on the HDMI-side pixel stream. Frames are
//               delimited by vsync edges; each frame gets line-width and
//               frame-height checks, per-channel pixel sums and a
//               rotate-XOR checksum. Results are latched at frame close
//               and announced by a one-cycle done strobe.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   hdmi_clk    in   1          pixel clock (only clock)
//   rst         in   1          synchronous active-high reset
//   hdmi_vs     in   1          vsync, frame open while high
//   hdmi_de     in   1          pixel valid
//   hdmi_data   in   DATA_W     pixel data, channel k at [k*CH_W +: CH_W]
//   frame_done  out  1          one-cycle pulse when results update
//   frame_cnt   out  16         completed frames (wraps)
//   frame_ok    out  1          last frame had no error
//   err_width   out  1          some line pixel count != IMG_W
//   err_height  out  1          line count at close != IMG_H
//   err_orphan  out  1          de seen outside an open frame
//   ch_sum      out  CH*SUM_W   per-channel sums, channel k at [k*SUM_W +: SUM_W]
//   checksum    out  32         rotate-XOR checksum of last frame
// ============================================================================
module hdmi_frame_monitor #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int DATA_W = 32,
   parameter int CH     = 3,
   parameter int CH_W   = 8,
   parameter int SUM_W  = 32
) (
   input  logic                  hdmi_clk,
   input  logic                  rst,
   input  logic                  hdmi_vs,
   input  logic                  hdmi_de,
   input  logic [DATA_W-1:0]     hdmi_data,
   output logic                  frame_done,
   output logic [15:0]           frame_cnt,
   output logic                  frame_ok,
   output logic                  err_width,
   output logic                  err_height,
   output logic                  err_orphan,
   output logic [CH*SUM_W-1:0]   ch_sum,
   output logic [31:0]           checksum
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_FRAME = 1'b1;

   localparam int              CNT_W     = 16;
   localparam logic [CNT_W-1:0] c_IMG_W   = CNT_W'(IMG_W);
   localparam logic [CNT_W-1:0] c_IMG_H   = CNT_W'(IMG_H);
   localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [0:0]                    r_state;
   logic                          r_vs_d;
   logic                          r_de_d;
   logic [CNT_W-1:0]              r_px_cnt;
   logic [CNT_W-1:0]              r_line_cnt;
   logic [CH-1:0][SUM_W-1:0]      r_sum;
   logic [31:0]                   r_cs;
   logic                          r_run_err_w;
   logic                          r_run_orphan;

   // Result registers
   logic                          r_done;
   logic [15:0]                   r_frame_cnt;
   logic                          r_ok;
   logic                          r_err_w;
   logic                          r_err_h;
   logic                          r_err_o;
   logic [CH-1:0][SUM_W-1:0]      r_res_sum;
   logic [31:0]                   r_res_cs;

   // ------------------------------------------------------------------------
   // Combinational next values
   // ------------------------------------------------------------------------
   logic                          w_in_frame;
   logic                          w_open;
   logic                          w_close;
   logic                          w_pix;
   logic                          w_line_end;
   logic [CNT_W-1:0]              w_px_inc;
   logic [CNT_W-1:0]              w_px_now;
   logic [CNT_W-1:0]              w_line_inc;
   logic [CNT_W-1:0]              w_line_now;
   logic                          w_width_bad;
   logic                          w_err_w_nxt;
   logic                          w_err_h_fin;
   logic [CH-1:0][CH_W-1:0]       w_ch;
   logic [CH-1:0][SUM_W-1:0]      w_sum_nxt;
   logic [31:0]                   w_px32;
   logic [31:0]                   w_cs_nxt;
   logic                          w_unused_data;

   // Upper data bits beyond the colour channels are intentionally ignored.
   assign w_unused_data = ^hdmi_data;

   assign w_in_frame = (r_state == S_FRAME);
   assign w_open     = (r_state == S_IDLE) && hdmi_vs && !r_vs_d;
   assign w_close    = w_in_frame && !hdmi_vs && r_vs_d;
   assign w_pix      = w_in_frame && hdmi_de;

   // A line ends on the de falling edge, or is forcibly terminated when a
   // pixel is still valid in the close cycle. The two cases are exclusive,
   // so a line is never counted twice.
   assign w_line_end = w_in_frame && ((!hdmi_de && r_de_d) || (w_close && hdmi_de));

   always_comb begin
      // Counters saturate so a runaway line/frame can never wrap back onto
      // the expected value and hide an error.
      w_px_inc   = (r_px_cnt   == '1) ? r_px_cnt   : r_px_cnt   + c_CNT_ONE;
      w_line_inc = (r_line_cnt == '1) ? r_line_cnt : r_line_cnt + c_CNT_ONE;

      // Pixel count of the current line including this cycle's pixel.
      w_px_now    = w_pix ? w_px_inc : r_px_cnt;
      w_line_now  = w_line_end ? w_line_inc : r_line_cnt;
      w_width_bad = w_line_end && (w_px_now != c_IMG_W);
      w_err_w_nxt = r_run_err_w | w_width_bad;
      w_err_h_fin = (w_line_now != c_IMG_H);
   end

   always_comb begin
      w_ch      = '0;
      w_sum_nxt = r_sum;
      for (int k = 0; k < CH; k++) begin
         w_ch[k] = hdmi_data[k*CH_W +: CH_W];
         if (w_pix) begin
            w_sum_nxt[k] = r_sum[k] + SUM_W'(w_ch[k]);
         end
      end
   end

   always_comb begin
      w_px32   = 32'(hdmi_data[CH*CH_W-1:0]);
      w_cs_nxt = w_pix ? ({r_cs[30:0], r_cs[31]} ^ w_px32) : r_cs;
   end

   // ------------------------------------------------------------------------
   // Sequential
   // ------------------------------------------------------------------------
   always_ff @(posedge hdmi_clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         // vs_d resets high so a frame already running at reset is ignored.
         r_vs_d       <= 1'b1;
         r_de_d       <= 1'b0;
         r_px_cnt     <= '0;
         r_line_cnt   <= '0;
         r_sum        <= '0;
         r_cs         <= '0;
         r_run_err_w  <= 1'b0;
         r_run_orphan <= 1'b0;
         r_done       <= 1'b0;
         r_frame_cnt  <= '0;
         r_ok         <= 1'b0;
         r_err_w      <= 1'b0;
         r_err_h      <= 1'b0;
         r_err_o      <= 1'b0;
         r_res_sum    <= '0;
         r_res_cs     <= '0;
      end else begin
         r_vs_d <= hdmi_vs;
         r_de_d <= hdmi_de;
         r_done <= 1'b0;

         if (w_open) begin
            r_state     <= S_FRAME;
            r_px_cnt    <= '0;
            r_line_cnt  <= '0;
            r_sum       <= '0;
            r_cs        <= '0;
            r_run_err_w <= 1'b0;
            // The orphan bit is only cleared once it has been published at
            // close, so a stray de seen while idle lands in this frame's
            // result. A pixel in the open cycle itself is discarded.
            r_run_orphan <= r_run_orphan | hdmi_de;
         end else if (w_in_frame) begin
            r_px_cnt    <= w_line_end ? '0 : w_px_now;
            r_line_cnt  <= w_line_now;
            r_sum       <= w_sum_nxt;
            r_cs        <= w_cs_nxt;
            r_run_err_w <= w_err_w_nxt;

            if (w_close) begin
               r_state      <= S_IDLE;
               r_done       <= 1'b1;
               r_frame_cnt  <= r_frame_cnt + 16'd1;
               r_res_sum    <= w_sum_nxt;
               r_res_cs     <= w_cs_nxt;
               r_err_w      <= w_err_w_nxt;
               r_err_h      <= w_err_h_fin;
               r_err_o      <= r_run_orphan;
               r_ok         <= !(w_err_w_nxt || w_err_h_fin || r_run_orphan);
               r_run_orphan <= 1'b0;
            end
         end else if (hdmi_de) begin
            r_run_orphan <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign frame_done = r_done;
   assign frame_cnt  = r_frame_cnt;
   assign frame_ok   = r_ok;
   assign err_width  = r_err_w;
   assign err_height = r_err_h;
   assign err_orphan = r_err_o;
   assign ch_sum     = r_res_sum;
   assign checksum   = r_res_cs;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_frame_monitor
// Description : Self-checking bench for hdmi_frame_monitor. Frames are
//               described as a list of line lengths; expected results are
//               computed from that list and the pixel values sent.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_frame_monitor;

   localparam int IMG_W  = 64;
   localparam int IMG_H  = 64;
   localparam int DATA_W = 32;
   localparam int CH     = 3;
   localparam int CH_W   = 8;
   localparam int SUM_W  = 32;

   logic                hdmi_clk;
   logic                rst;
   logic                hdmi_vs;
   logic                hdmi_de;
   logic [DATA_W-1:0]   hdmi_data;
   logic                frame_done;
   logic [15:0]         frame_cnt;
   logic                frame_ok;
   logic                err_width;
   logic                err_height;
   logic                err_orphan;
   logic [CH*SUM_W-1:0] ch_sum;
   logic [31:0]         checksum;

   int n_checks = 0;
   int n_errors = 0;
   int n_done   = 0;
   int exp_done = 0;
   logic [15:0] exp_cnt = '0;
   int q_lens[$];

   hdmi_frame_monitor #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .DATA_W(DATA_W),
      .CH    (CH),
      .CH_W  (CH_W),
      .SUM_W (SUM_W)
   ) u_dut (
      .hdmi_clk  (hdmi_clk),
      .rst       (rst),
      .hdmi_vs   (hdmi_vs),
      .hdmi_de   (hdmi_de),
      .hdmi_data (hdmi_data),
      .frame_done(frame_done),
      .frame_cnt (frame_cnt),
      .frame_ok  (frame_ok),
      .err_width (err_width),
      .err_height(err_height),
      .err_orphan(err_orphan),
      .ch_sum    (ch_sum),
      .checksum  (checksum)
   );

   initial hdmi_clk = 1'b0;
   always #5 hdmi_clk = ~hdmi_clk;

   always @(negedge hdmi_clk) begin
      if (frame_done === 1'b1) n_done++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge hdmi_clk);
      #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_done"},     128'(frame_done), 128'(0));
      check_eq({tag, "_cnt"},      128'(frame_cnt),  128'(0));
      check_eq({tag, "_ok"},       128'(frame_ok),   128'(0));
      check_eq({tag, "_errw"},     128'(err_width),  128'(0));
      check_eq({tag, "_errh"},     128'(err_height), 128'(0));
      check_eq({tag, "_erro"},     128'(err_orphan), 128'(0));
      check_eq({tag, "_sum"},      128'(ch_sum),     128'(0));
      check_eq({tag, "_checksum"}, 128'(checksum),   128'(0));
   endtask

   task automatic fill_lens(input int n, input int len);
      q_lens.delete();
      for (int i = 0; i < n; i++) q_lens.push_back(len);
   endtask

   // Drives one frame described by q_lens and checks the published results
   // against sums/checksum/error flags computed from what was sent.
   task automatic send_frame(input bit orphan_before, input bit last_in_close,
                             input bit fixed_data, input string tag);
      logic [SUM_W-1:0]    m_sum [CH];
      logic [CH*SUM_W-1:0] m_pack;
      logic [31:0]         m_cs;
      logic [31:0]         d;
      bit                  m_werr;
      bit                  m_herr;
      bit                  m_ok;
      bit                  last;
      int                  nl;
      nl     = q_lens.size();
      m_cs   = '0;
      m_werr = 1'b0;
      for (int k = 0; k < CH; k++) m_sum[k] = '0;

      hdmi_vs = 1'b0; hdmi_de = 1'b0; hdmi_data = $urandom();
      tick(); tick();
      if (orphan_before) begin
         hdmi_de = 1'b1; hdmi_data = $urandom();
         tick();
         hdmi_de = 1'b0;
         tick();
      end
      hdmi_vs = 1'b1;
      tick();
      for (int li = 0; li < nl; li++) begin
         if (q_lens[li] != IMG_W) m_werr = 1'b1;
         for (int p = 0; p < q_lens[li]; p++) begin
            last = last_in_close && (li == nl - 1) && (p == q_lens[li] - 1);
            d = fixed_data ? 32'h0001_0203 : $urandom();
            if (last) d = {d[31:8], 8'hFF};
            for (int k = 0; k < CH; k++) m_sum[k] += SUM_W'(d[k*CH_W +: CH_W]);
            m_cs = {m_cs[30:0], m_cs[31]} ^ (d & 32'h00FF_FFFF);
            hdmi_data = d;
            hdmi_de   = 1'b1;
            if (last) hdmi_vs = 1'b0;
            tick();
         end
         if (!(last_in_close && li == nl - 1)) begin
            hdmi_de = 1'b0; hdmi_data = $urandom();
            repeat ($urandom_range(1, 2)) tick();
         end
      end
      if (!(last_in_close && nl > 0)) begin
         hdmi_vs = 1'b0; hdmi_de = 1'b0;
         tick();
      end

      m_herr = (nl != IMG_H);
      m_ok   = !(m_werr || m_herr || orphan_before);
      for (int k = 0; k < CH; k++) m_pack[k*SUM_W +: SUM_W] = m_sum[k];
      exp_cnt  = exp_cnt + 16'd1;
      exp_done++;

      check_eq({tag, "_done"},     128'(frame_done), 128'(1));
      check_eq({tag, "_cnt"},      128'(frame_cnt),  128'(exp_cnt));
      check_eq({tag, "_ok"},       128'(frame_ok),   128'(m_ok));
      check_eq({tag, "_errw"},     128'(err_width),  128'(m_werr));
      check_eq({tag, "_errh"},     128'(err_height), 128'(m_herr));
      check_eq({tag, "_erro"},     128'(err_orphan), 128'(orphan_before));
      check_eq({tag, "_sum"},      128'(ch_sum),     128'(m_pack));
      check_eq({tag, "_checksum"}, 128'(checksum),   128'(m_cs));

      hdmi_vs = 1'b0; hdmi_de = 1'b0; hdmi_data = $urandom();
      tick();
      check_eq({tag, "_done_pulse"}, 128'(frame_done), 128'(0));
      check_eq({tag, "_hold_cnt"},   128'(frame_cnt),  128'(exp_cnt));
   endtask

   initial begin
      int nl;
      int snap;
      rst = 1'b1; hdmi_vs = 1'b1; hdmi_de = 1'b0; hdmi_data = '0;
      repeat (3) tick();
      check_zero_outputs("reset");

      // vs already high when reset releases: must not be captured as a frame.
      rst = 1'b0;
      repeat (5) tick();
      hdmi_vs = 1'b0;
      repeat (3) tick();
      check_eq("no_frame_after_reset", 128'(n_done), 128'(0));

      // Two clean frames of constant pixels.
      fill_lens(IMG_H, IMG_W);
      send_frame(1'b0, 1'b0, 1'b1, "clean1");
      send_frame(1'b0, 1'b0, 1'b1, "clean2");
      check_eq("clean2_cnt_const", 128'(frame_cnt), 128'(2));
      check_eq("clean2_ok_const",  128'(frame_ok),  128'(1));
      check_eq("clean2_sum_const", 128'(ch_sum),
               128'({32'h0000_1000, 32'h0000_2000, 32'h0000_3000}));
      check_eq("clean2_cs_const",  128'(checksum),  128'(0));

      // Line 10 short by one pixel.
      fill_lens(IMG_H, IMG_W);
      q_lens[10] = IMG_W - 1;
      send_frame(1'b0, 1'b0, 1'b0, "short_line");
      check_eq("short_line_errw_const", 128'(err_width), 128'(1));

      // One line missing.
      fill_lens(IMG_H - 1, IMG_W);
      send_frame(1'b0, 1'b0, 1'b0, "short_frame");
      check_eq("short_frame_errh_const", 128'(err_height), 128'(1));

      // Orphan de while idle, then a clean frame.
      fill_lens(IMG_H, IMG_W);
      send_frame(1'b1, 1'b0, 1'b0, "orphan");
      send_frame(1'b0, 1'b0, 1'b0, "after_orphan");
      check_eq("after_orphan_ok_const", 128'(frame_ok), 128'(1));

      // Last pixel presented in the close cycle.
      send_frame(1'b0, 1'b1, 1'b0, "last_in_close");
      check_eq("last_in_close_ok_const", 128'(frame_ok), 128'(1));

      // Empty frame: vs high without pixels.
      q_lens.delete();
      send_frame(1'b0, 1'b0, 1'b0, "empty");

      // Reset in the middle of line 30.
      hdmi_vs = 1'b0; hdmi_de = 1'b0;
      tick(); tick();
      hdmi_vs = 1'b1;
      tick();
      for (int li = 0; li < 30; li++) begin
         for (int p = 0; p < IMG_W; p++) begin
            hdmi_de = 1'b1; hdmi_data = $urandom();
            tick();
         end
         hdmi_de = 1'b0;
         tick();
      end
      for (int p = 0; p < 20; p++) begin
         hdmi_de = 1'b1; hdmi_data = $urandom();
         tick();
      end
      snap = n_done;
      rst = 1'b1;
      tick();
      check_zero_outputs("mid_reset");
      rst = 1'b0; hdmi_vs = 1'b0; hdmi_de = 1'b0;
      tick(); tick();
      check_eq("mid_reset_no_done", 128'(n_done), 128'(snap));
      exp_cnt = '0;
      fill_lens(IMG_H, IMG_W);
      send_frame(1'b0, 1'b0, 1'b0, "post_reset");
      check_eq("post_reset_cnt_const", 128'(frame_cnt), 128'(1));
      check_eq("post_reset_ok_const",  128'(frame_ok),  128'(1));

      // Randomised frames around the nominal geometry.
      for (int f = 0; f < 3; f++) begin
         nl = IMG_H - 1 + int'($urandom_range(0, 2));
         q_lens.delete();
         for (int i = 0; i < nl; i++) begin
            if ($urandom_range(0, 15) == 0)
               q_lens.push_back(IMG_W - 1 + 2 * int'($urandom_range(0, 1)));
            else
               q_lens.push_back(IMG_W);
         end
         send_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                    $sformatf("rand%0d", f));
      end

      repeat (3) tick();
      check_eq("total_done_pulses", 128'(n_done), 128'(exp_done));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
